alu_exec_unit: RTL and testbench

Multi-cycle execution unit on the receiving end of the 4-bit ALUControl code produced by the ALU decoder. Latches operands and control code through a valid/ready handshake, executes arithmetic/logic ops in one cycle and shifts iteratively (1 bit/cycle), then holds the result until the consumer accepts it. Sits between decode/register-read and writeback in the multi-cycle datapath variant of the CPU.

---
 rtl/alu_exec_if.sv | 60 ++++++
 rtl/alu_exec_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// -----------------------------------------------------------------------------
// alu_exec_if
// Handshake bundle between the register-read/decode stage, the multi-cycle
// ALU execution unit and the writeback consumer.
//
// Signals:
//   in_valid   producer -> unit   operands/control present
//   in_ready   unit -> producer   unit can accept (IDLE only)
//   ALUControl producer -> unit   4-bit ALU decoder code
//   a, b       producer -> unit   operands (a = shift source, b[SHW-1:0] = shamt)
//   out_valid  unit -> consumer   result available
//   out_ready  consumer -> unit   consumer accepts result
//   result     unit -> consumer   op result
//   zero       unit -> consumer   result == 0
//   illegal    unit -> consumer   ALUControl code undefined
//
// Modports:
//   slave  - the execution unit side
//   master - the producer/consumer (environment) side
// -----------------------------------------------------------------------------
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport slave (
        input  in_valid,
        output in_ready,
        input  ALUControl,
        input  a,
        input  b,
        output out_valid,
        input  out_ready,
        output result,
        output zero,
        output illegal
    );

    modport master (
        output in_valid,
        input  in_ready,
        output ALUControl,
        output a,
        output b,
        input  out_valid,
        output out_ready,
        input  result,
        input  zero,
        input  illegal
    );
endinterface : alu_exec_if

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle execution unit driven by the ALU decoder's 4-bit ALUControl.
// Accepts operands through a valid/ready handshake, computes arithmetic and
// logic ops in the accept cycle, runs shifts one bit per cycle, and holds the
// result in DONE until the consumer takes it.
//
// Ports:
//   clk    - clock, all logic on the rising edge
//   reset  - synchronous, active-low (0 = reset)
//   bus    - alu_exec_if.slave (in_valid/in_ready/ALUControl/a/b,
//            out_valid/out_ready/result/zero/illegal)
//
// Parameters:
//   WIDTH  - operand/result width, power of two, >= 8
//
// Build option:
//   ALU_BARREL_SHIFT_EN - when defined, shifts are computed combinationally at
//   accept and the SHIFT state / shift counter are not built (all ops take one
//   cycle). When undefined, an iterative 1-bit/cycle shifter is used.
//
// Codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt,
//        0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010-1111 illegal.
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_exec_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Single-cycle arithmetic/logic result; shifts and illegal codes give 0.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op > OP_SRA);
    endfunction

`ifdef ALU_BARREL_SHIFT_EN
    // Full-amount shift used when the barrel shifter is built.
    function automatic logic [WIDTH-1:0] barrel_fn(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [SHW-1:0] sh);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = x << sh;
            OP_SRL:  r = x >> sh;
            OP_SRA:  r = $unsigned($signed(x) >>> sh);
            default: r = x;
        endcase
        return r;
    endfunction
`else
    // One-bit step of the iterative shifter.
    function automatic logic [WIDTH-1:0] shift1_fn(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {x[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, x[WIDTH-1:1]};
            OP_SRA:  r = {x[WIDTH-1], x[WIDTH-1:1]};
            default: r = x;
        endcase
        return r;
    endfunction

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);
`endif

    state_t           state_r,     state_nxt_s;
    logic [WIDTH-1:0] result_r,    result_nxt_s;
    logic             zero_r,      zero_nxt_s;
    logic             illegal_r,   illegal_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic [WIDTH-1:0] alu_res_s;
    logic [SHW-1:0]   shamt_s;
`ifndef ALU_BARREL_SHIFT_EN
    logic [SHW-1:0]   cnt_r,       cnt_nxt_s;
    logic [3:0]       op_r,        op_nxt_s;
    logic [WIDTH-1:0] shifted_s;
`endif

    // Upper bits of b are ignored for shifts.
    assign shamt_s   = bus.b[SHW-1:0];
    assign alu_res_s = alu_fn(bus.ALUControl, bus.a, bus.b);
`ifndef ALU_BARREL_SHIFT_EN
    assign shifted_s = shift1_fn(op_r, result_r);
`endif

    // in_ready is a state decode, forced low while reset is held.
    assign bus.in_ready  = (state_r == ST_IDLE) && reset;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.illegal   = illegal_r;

    // Next-state and datapath-next computation for the control FSM.
    always_comb begin
        state_nxt_s     = state_r;
        result_nxt_s    = result_r;
        zero_nxt_s      = zero_r;
        illegal_nxt_s   = illegal_r;
        out_valid_nxt_s = out_valid_r;
`ifndef ALU_BARREL_SHIFT_EN
        cnt_nxt_s       = cnt_r;
        op_nxt_s        = op_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift(bus.ALUControl)) begin
`ifdef ALU_BARREL_SHIFT_EN
                        result_nxt_s    = barrel_fn(bus.ALUControl, bus.a, shamt_s);
                        zero_nxt_s      = (barrel_fn(bus.ALUControl, bus.a, shamt_s) == {WIDTH{1'b0}});
                        illegal_nxt_s   = 1'b0;
                        out_valid_nxt_s = 1'b1;
                        state_nxt_s     = ST_DONE;
`else
                        op_nxt_s      = bus.ALUControl;
                        cnt_nxt_s     = shamt_s;
                        result_nxt_s  = bus.a;
                        illegal_nxt_s = 1'b0;
                        if (shamt_s == {SHW{1'b0}}) begin
                            zero_nxt_s      = (bus.a == {WIDTH{1'b0}});
                            out_valid_nxt_s = 1'b1;
                            state_nxt_s     = ST_DONE;
                        end else begin
                            zero_nxt_s      = 1'b0;
                            out_valid_nxt_s = 1'b0;
                            state_nxt_s     = ST_SHIFT;
                        end
`endif
                    end else begin
                        // Illegal codes fall out of alu_fn as 0, so zero=1.
                        result_nxt_s    = alu_res_s;
                        zero_nxt_s      = (alu_res_s == {WIDTH{1'b0}});
                        illegal_nxt_s   = is_illegal(bus.ALUControl);
                        out_valid_nxt_s = 1'b1;
                        state_nxt_s     = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                result_nxt_s = shifted_s;
                cnt_nxt_s    = cnt_r - CNT_ONE;
                // The final shift step lands together with the move to DONE.
                if (cnt_r == CNT_ONE) begin
                    zero_nxt_s      = (shifted_s == {WIDTH{1'b0}});
                    out_valid_nxt_s = 1'b1;
                    state_nxt_s     = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
`endif
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            cnt_r       <= {SHW{1'b0}};
            op_r        <= 4'b0000;
`endif
        end else begin
            state_r     <= state_nxt_s;
            result_r    <= result_nxt_s;
            zero_r      <= zero_nxt_s;
            illegal_r   <= illegal_nxt_s;
            out_valid_r <= out_valid_nxt_s;
`ifndef ALU_BARREL_SHIFT_EN
            cnt_r       <= cnt_nxt_s;
            op_r        <= op_nxt_s;
`endif
        end
    end

endmodule : alu_exec_unit

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit: table of directed vectors with
// hand-computed results plus sequences for reset, DONE hold and reset
// during a shift. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;
    localparam int WIDTH = 32;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_exec_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int shift_lat(input int shamt);
        return BARREL ? 1 : 1 + shamt;
    endfunction

    // Issue one op from IDLE, wait for the result, check it and hand it off.
    task automatic run_op(input vec_t v);
        int lat;
        chk({v.name, " in_ready_idle"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid   = 1'b1;
        bus.ALUControl = v.ctl;
        bus.a          = v.a;
        bus.b          = v.b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h0000_0003;
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({v.name, " result"},    bus.result, v.exp_res);
        chk({v.name, " zero"},      {31'd0, bus.zero}, {31'd0, v.exp_zero});
        chk({v.name, " illegal"},   {31'd0, bus.illegal}, {31'd0, v.exp_ill});
        chk({v.name, " latency"},   lat, v.exp_lat);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({v.name, " out_valid_after"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{"add_ovf",  4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1};
        vecs[1]  = '{"sub_eq",   4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[2]  = '{"and",      4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1};
        vecs[3]  = '{"or",       4'b0011, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1};
        vecs[4]  = '{"xor",      4'b0100, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0, 1};
        vecs[5]  = '{"slt",      4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1};
        vecs[6]  = '{"sltu",     4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[7]  = '{"sra4",     4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, shift_lat(4)};
        vecs[8]  = '{"srl4",     4'b1000, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0, shift_lat(4)};
        vecs[9]  = '{"sll31",    4'b0111, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, shift_lat(31)};
        vecs[10] = '{"sll0",     4'b0111, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1};
        vecs[11] = '{"ill1100",  4'b1100, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1};
        vecs[12] = '{"ill1111",  4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1};
        vecs[13] = '{"sub_wrap", 4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
        vecs[14] = '{"add_zero", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[15] = '{"slt_neg",  4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[16] = '{"sra_pos",  4'b1001, 32'h7FFF_FFFF, 32'hFFFF_FFE1, 32'h3FFF_FFFF, 1'b0, 1'b0, shift_lat(1)};
        vecs[17] = '{"srl_out",  4'b1000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, shift_lat(1)};

        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.ALUControl = 4'b0000;
        bus.a          = 32'h0;
        bus.b          = 32'h0;
        bus.out_ready  = 1'b0;

        // Reset held for two edges.
        @(negedge clk);
        @(negedge clk);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst result",    bus.result, 32'd0);
        chk("rst zero",      {31'd0, bus.zero}, 32'd0);
        chk("rst illegal",   {31'd0, bus.illegal}, 32'd0);
        chk("rst in_ready",  {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst in_ready", {31'd0, bus.in_ready}, 32'd1);

        // out_ready while nothing is pending must not disturb anything.
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle out_ready", {31'd0, bus.out_valid}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i]);
        end

        // Result held in DONE while the consumer stalls; new in_valid ignored.
        bus.in_valid   = 1'b1;
        bus.ALUControl = 4'b0000;
        bus.a          = 32'd3;
        bus.b          = 32'd4;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            bus.in_valid   = k[0];
            bus.ALUControl = 4'b0001;
            bus.a          = 32'h0000_0100;
            bus.b          = 32'h0000_0001;
            chk("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold result",    bus.result, 32'd7);
            chk("hold in_ready",  {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        chk("hold final result", bus.result, 32'd7);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("handoff out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("handoff in_ready",  {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        chk("no stray accept", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a 20-bit left shift aborts the op.
        bus.in_valid   = 1'b1;
        bus.ALUControl = 4'b0111;
        bus.a          = 32'h0000_0001;
        bus.b          = 32'd20;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst result",    bus.result, 32'd0);
        chk("mid_rst in_ready",  {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst idle", {31'd0, bus.in_ready}, 32'd1);
        for (int k = 0; k < 25; k++) @(negedge clk);
        chk("mid_rst no result", {31'd0, bus.out_valid}, 32'd0);

        // Unit is fully usable after the aborted shift.
        run_op('{"after_rst", 4'b0000, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_alu_exec_unit
